// File: rtl/adc_sweep_sequencer_pkg.sv
// adc_sweep_sequencer_pkg: shared sweep state encoding and default sweep constants
package adc_sweep_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, PRESENT} state_t;
    localparam int DEF_ADC_BITS = 8;
    localparam int DEF_NUM_POINTS = 64;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES = 64;
endpackage

// File: rtl/adc_sweep_sequencer_pair_capture.sv
// adc_pair_capture: latches both SAR results and tracks which conversions have completed
module adc_pair_capture #(
    parameter int ADC_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                f_done,
    input  logic                a_done,
    input  logic [ADC_BITS-1:0] f_data,
    input  logic [ADC_BITS-1:0] a_data,
    output logic [ADC_BITS-1:0] f_code,
    output logic [ADC_BITS-1:0] a_code,
    output logic                both_done
);
    logic f_got;
    logic a_got;
    // includes same-cycle dones so the completing edge can advance the FSM
    assign both_done = en & (f_got | f_done) & (a_got | a_done);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_got <= 1'b0;
            a_got <= 1'b0;
            f_code <= '0;
            a_code <= '0;
        end else begin
            f_got <= !clr & (f_got | (en & f_done));
            a_got <= !clr & (a_got | (en & a_done));
            if (en & f_done) f_code <= f_data;
            if (en & a_done) a_code <= a_data;
        end
    end
endmodule

// File: rtl/adc_sweep_sequencer.sv
// adc_sweep_sequencer: settle/convert/present sweep of paired SAR conversions with timeout and abort
module adc_sweep_sequencer
    import adc_sweep_sequencer_pkg::*;
#(
    parameter int ADC_BITS = DEF_ADC_BITS,
    parameter int NUM_POINTS = DEF_NUM_POINTS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W = NUM_POINTS > 1 ? $clog2(NUM_POINTS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sweep_start,
    input  logic                sweep_abort,
    input  logic                frequency_adc_done,
    input  logic                amplitude_adc_done,
    input  logic [ADC_BITS-1:0] sig_frequency,
    input  logic [ADC_BITS-1:0] sig_amplitude,
    output logic                adc_start,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [ADC_BITS-1:0] sample_freq,
    output logic [ADC_BITS-1:0] sample_amp,
    output logic [IDX_W-1:0]    sample_index,
    output logic                sweep_busy,
    output logic                sweep_done,
    output logic                timeout_err
);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);
    localparam logic DIRECT = SETTLE_CYCLES == 0;
    localparam state_t FIRST = DIRECT ? CONVERT : SETTLE;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic [TW-1:0]   conv_cnt;
    logic            both_done;

    adc_pair_capture #(.ADC_BITS(ADC_BITS)) u_capture (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state == CONVERT),
        .clr       (state != CONVERT),
        .f_done    (frequency_adc_done),
        .a_done    (amplitude_adc_done),
        .f_data    (sig_frequency),
        .a_data    (sig_amplitude),
        .f_code    (sample_freq),
        .a_code    (sample_amp),
        .both_done (both_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            settle_cnt <= '0;
            conv_cnt <= '0;
            sample_index <= '0;
            adc_start <= 1'b0;
            sample_valid <= 1'b0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            adc_start <= 1'b0;
            sweep_done <= 1'b0;
            if (sweep_abort) begin
                state <= IDLE;
                sample_valid <= 1'b0;
                sweep_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (sweep_start) begin
                        timeout_err <= 1'b0;
                        sample_index <= '0;
                        sweep_busy <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        conv_cnt <= '0;
                        state <= FIRST;
                        adc_start <= DIRECT;
                    end
                    SETTLE: begin
                        settle_cnt <= settle_cnt - 1'b1;
                        if (settle_cnt == '0) begin
                            state <= CONVERT;
                            adc_start <= 1'b1;
                            conv_cnt <= '0;
                        end
                    end
                    // a completing done on the last allowed cycle beats the timeout
                    CONVERT: if (both_done) begin
                        state <= PRESENT;
                        sample_valid <= 1'b1;
                    end else if (conv_cnt == TIMEOUT_LAST) begin
                        state <= IDLE;
                        timeout_err <= 1'b1;
                        sweep_busy <= 1'b0;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                    PRESENT: if (sample_ready) begin
                        sample_valid <= 1'b0;
                        if (sample_index == LAST_IDX) begin
                            state <= IDLE;
                            sweep_busy <= 1'b0;
                            sweep_done <= 1'b1;
                        end else begin
                            sample_index <= sample_index + 1'b1;
                            settle_cnt <= SETTLE_LOAD;
                            conv_cnt <= '0;
                            state <= FIRST;
                            adc_start <= DIRECT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
